// File: rtl/rca_seq_pkg.sv
// Shared constants and state encoding for the multi-precision RCA add sequencer.
package rca_seq_pkg;

  localparam int W_DEF     = 32;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_mp_seq.sv
// Multi-precision add sequencer: feeds one external W-bit RCA a word per cycle, LS word first.
// Optional subtract mode (a - b via ~b and carry-in 1) enabled by defining RCA_MP_SEQ_SUB_EN.
module rca_mp_seq
  import rca_seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W*WORDS-1:0]   a,
  input  logic [W*WORDS-1:0]   b,
  input  logic                 cin,
`ifdef RCA_MP_SEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [W*WORDS-1:0]   sum,
  output logic                 cout,
  output logic [W-1:0]         rca_a,
  output logic [W-1:0]         rca_b,
  output logic                 rca_cin,
  input  logic [W-1:0]         rca_sum,
  input  logic                 rca_cout
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_t               state_q;
  logic [IDXW-1:0]      idx_q;
  logic [W*WORDS-1:0]   a_q, b_q, sum_q;
  logic                 carry_q, busy_q, done_q, cout_q;

  logic [W*WORDS-1:0]   b_d;
  logic                 carry_d;

`ifdef RCA_MP_SEQ_SUB_EN
  // Subtraction as a + ~b + 1; cout then reads as "no borrow".
  assign b_d     = sub ? ~b : b;
  assign carry_d = sub ? 1'b1 : cin;
`else
  assign b_d     = b;
  assign carry_d = cin;
`endif

  always_comb begin
    rca_a   = '0;
    rca_b   = '0;
    rca_cin = 1'b0;
    if (state_q == RUN) begin
      rca_a   = a_q[W*int'(idx_q) +: W];
      rca_b   = b_q[W*int'(idx_q) +: W];
      rca_cin = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[W*int'(idx_q) +: W] <= rca_sum;
          carry_q                   <= rca_cout;
          if (idx_q == LAST_IDX) begin
            cout_q  <= rca_cout;
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_rca_mp_seq.sv
// Self-checking bench for rca_mp_seq with a behavioural RCA attached; randomized ops vs a wide-arithmetic model.
module tb_rca_mp_seq;

  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           cin = 1'b0;
`ifdef RCA_MP_SEQ_SUB_EN
  logic           sub = 1'b0;
`endif
  logic           busy, done, cout, rca_cin, rca_cout;
  logic [N-1:0]   sum;
  logic [W-1:0]   rca_a, rca_b, rca_sum;
  logic [W:0]     rca_full;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rca_full = {1'b0, rca_a} + {1'b0, rca_b} + {{W{1'b0}}, rca_cin};
  assign rca_sum  = rca_full[W-1:0];
  assign rca_cout = rca_full[W];

  rca_mp_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef RCA_MP_SEQ_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .rca_a    (rca_a),
    .rca_b    (rca_b),
    .rca_cin  (rca_cin),
    .rca_sum  (rca_sum),
    .rca_cout (rca_cout)
  );

  task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N:0] ref_model(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                           input logic rc, input logic rs);
    if (rs) return {1'b0, ra} + {1'b0, ~rb} + (N+1)'(1);
    return {1'b0, ra} + {1'b0, rb} + (N+1)'(rc);
  endfunction

  // Full transaction: start, latency, busy span, result, and idle afterwards.
  task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input logic tc, input logic ts);
    logic [N:0] exp;
    int n, busy_cnt;
    exp = ref_model(ta, tb_, tc, ts);
    a = ta; b = tb_; cin = tc; start = 1'b1;
`ifdef RCA_MP_SEQ_SUB_EN
    sub = ts;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    a = N'({$urandom, $urandom, $urandom, $urandom});
    b = N'({$urandom, $urandom, $urandom, $urandom});
    busy_cnt = busy ? 1 : 0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
    end
    chk({tag, ".latency"}, (N+1)'(n), (N+1)'(WORDS));
    chk({tag, ".busy_span"}, (N+1)'(busy_cnt), (N+1)'(WORDS + 1));
    chk({tag, ".sum"}, {1'b0, sum}, {1'b0, exp[N-1:0]});
    chk({tag, ".cout"}, (N+1)'(cout), (N+1)'(exp[N]));
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, (N+1)'(done), '0);
    chk({tag, ".idle"}, (N+1)'(busy), '0);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic [N:0]   exp1;
    int dones;

    #2;
    chk("rst.busy", (N+1)'(busy), '0);
    chk("rst.done", (N+1)'(done), '0);
    chk("rst.sum", {1'b0, sum}, '0);
    chk("rst.cout", (N+1)'(cout), '0);
    chk("rst.rca", (N+1)'({rca_a, rca_b, rca_cin}), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("ripple", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1'b0);
    chk("ripple.const", {1'b0, sum}, {1'b0, 128'h0000_0000_0000_0000_0000_0001_0000_0000});
    run_op("wrap", {N{1'b1}}, '0, 1'b1, 1'b0);
    chk("wrap.const", {cout, sum}, {1'b1, 128'h0});
    run_op("plain", 128'h0000000f_00000008_10000fff_00000005,
                    128'h0000ffff_00000005_0000ffff_00000002, 1'b0, 1'b0);
    chk("plain.const", {cout, sum}, {1'b0, 128'h0001000e_0000000d_10010ffe_00000007});
    run_op("ones_ones", {N{1'b1}}, {N{1'b1}}, 1'b1, 1'b0);

    // Extra starts while busy must be ignored.
    ra = N'({$urandom, $urandom, $urandom, $urandom});
    rb = N'({$urandom, $urandom, $urandom, $urandom});
    exp1 = ref_model(ra, rb, 1'b1, 1'b0);
    a = ra; b = rb; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 14; k++) begin
      a = ~ra; b = ~rb; cin = 1'b0;
      start = (k == 1 || k == WORDS);
      @(posedge clk); #1;
      if (done) begin
        dones++;
        chk("busy_start.sum", {cout, sum}, exp1);
      end
    end
    start = 1'b0;
    chk("busy_start.dones", (N+1)'(dones), (N+1)'(1));

    // Reset in the middle of a run.
    a = {N{1'b1}}; b = 128'h1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst.busy", (N+1)'(busy), '0);
    chk("midrst.sum", {cout, sum}, '0);
    chk("midrst.rca_a", (N+1)'(rca_a), '0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (k == 2) rst = 1'b0;
    end
    chk("midrst.no_done", (N+1)'(dones), '0);
    run_op("after_rst", 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, {N{1'b1}}, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = N'({$urandom, $urandom, $urandom, $urandom});
      rb = N'({$urandom, $urandom, $urandom, $urandom});
      if (i % 4 == 1) rb = ~ra;
      run_op("rand", ra, rb, 1'($urandom), 1'b0);
    end

`ifdef RCA_MP_SEQ_SUB_EN
    run_op("sub_neg", 128'h5, 128'h8, 1'b0, 1'b1);
    chk("sub_neg.const", {cout, sum}, {1'b0, {N{1'b1}} - 128'h2});
    run_op("sub_pos", 128'h8, 128'h5, 1'b1, 1'b1);
    chk("sub_pos.const", {cout, sum}, {1'b1, 128'h3});
    for (int i = 0; i < 8; i++) begin
      ra = N'({$urandom, $urandom, $urandom, $urandom});
      rb = N'({$urandom, $urandom, $urandom, $urandom});
      run_op("rand_sub", ra, rb, 1'($urandom), 1'($urandom));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_mp_seq.md
Name: rca_mp_seq

Overview:
- Multi-precision add sequencer that time-multiplexes the existing 32-bit ripple-carry adder (RCA module) to add WORDS×32-bit operands, one word per cycle, least-significant word first.
- Carry is chained through a register between passes.
- Sits beside a single RCA instance: this block drives the RCA operand/carry inputs and captures its sum/carry outputs.
- Used wherever wide add/accumulate is needed without replicating adders.

Parameters:
- W, 32, word width; must match the attached RCA.
- WORDS, 4, number of words per operand; legal range 2..16.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- a  in  W*WORDS  operand A, sampled on accepted start
- b  in  W*WORDS  operand B, sampled on accepted start
- cin  in  1  initial carry, sampled on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result valid
- sum  out  W*WORDS  registered result; holds until next accepted start
- cout  out  1  final carry; registered, holds with sum
- rca_a  out  W  to RCA .a
- rca_b  out  W  to RCA .b
- rca_cin  out  1  to RCA .cin
- rca_sum  in  W  from RCA .sum (combinational, same cycle)
- rca_cout  in  1  from RCA .cout (combinational, same cycle)

Behaviour:
- Reset (async, any state) clears:
  - state to IDLE and idx to 0
  - busy, done, cout, carry register, sum, and the a_q/b_q operand registers
  - rca_a, rca_b and rca_cin to 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - rca_* outputs are 0.
  - start=1: latch a→a_q, b→b_q, cin→carry, idx←0; go to RUN.
- RUN:
  - Drive rca_a=a_q[idx], rca_b=b_q[idx], rca_cin=carry.
  - On each clock: sum word idx←rca_sum, carry←rca_cout, idx←idx+1.
  - When idx==WORDS-1: go to DONE, with cout←rca_cout in the same edge.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - rca_* outputs are 0.
- Latency: start accepted at edge 0 → done high in the cycle after edge WORDS. That is WORDS+1 cycles from the start cycle to the done cycle, and throughput is one op per WORDS+2 cycles.
- start while busy (RUN or DONE): ignored; no latch and no state change.
- sum words not yet written in the current op keep their previous values. They are fully overwritten by done; the bench checks sum only at done or later.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W*WORDS+1). The carry chain wraps correctly across all word boundaries, including all-ones operands.
- idx width: clog2(WORDS). idx never exceeds WORDS-1.

Optional Feature:
- Macro: RCA_MP_SEQ_SUB_EN
- When defined:
  - Extra input port sub (1 bit), sampled with start.
  - sub=1: b_q←~b and carry←1, with cin ignored. The result is a−b, and cout=1 means no borrow (a≥b unsigned).
  - sub=0: identical to plain add.
- When undefined: no sub port, add only; logic identical to the sub=0 path.

Decomposition:
- Shared package rca_seq_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default W=32 and WORDS=4 constants
- No internal sub-module.
  - The RCA stays a separate, externally instantiated module so one adder can later be shared with other requesters through an arbiter.
  - The word select/insert logic stays inline.

Test Plan (W=32, WORDS=4, RCA instance wired):
- Carry ripple across words: a=128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=128'h1, cin=0, start 1 cycle → done pulses 5 cycles after start cycle, sum=128'h0000_0000_0000_0000_0000_0001_0000_0000, cout=0.
- Full wrap: a=all-ones, b=0, cin=1 → sum=128'h0, cout=1; busy high for exactly 5 cycles.
- Plain word values: a=128'h0000000f_00000008_10000fff_00000005, b=128'h0000ffff_00000005_0000ffff_00000002, cin=0 → sum=128'h0001000e_0000000d_10010ffe_00000007, cout=0.
- Start while busy: second start with different operands asserted in cycles 2 and 5 after the first → ignored; result equals the first op; no second done.
- Reset mid-op: assert rst at cycle 2 of RUN → busy=0, done never pulses, sum=0, cout=0, rca_a=0 immediately; a new start after release completes normally.
- RCA_MP_SEQ_SUB_EN defined:
  - a=5, b=8, sub=1 → sum=128'hFFFF…FFFD, cout=0.
  - a=8, b=5, sub=1 → sum=3, cout=1.
